// File: rtl/inst_v2k_resp_chk.sv
// Self-timed response checker for the v2k instance-port sub-block.
// Latches an expected bus value on start and checks ready arrival, bus stability and the tie-off.
module inst_v2k_resp_chk #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [1:0]  TIED_EXP = 2'b10,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] exp_sized,
  input  logic [WIDTH-1:0] osizedreg,
  input  logic             oonewire,
  input  logic [1:0]       tied,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [3:0]       err_count,
  output logic [7:0]       lat_cnt
);

  localparam int unsigned LW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned EW = 4;

  localparam logic [LW-1:0] TIMEOUT_L = LW'(TIMEOUT);
  localparam logic [SW-1:0] SETTLE_S  = SW'(SETTLE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_PASS   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] prev_sz_q;
  logic             prev_one_q;
  logic [SW-1:0]    settle_q, settle_d;
  logic [LW-1:0]    tot_q, tot_d;
  logic [EW-1:0]    err_d;
  logic [LW-1:0]    lat_d;
  logic             to_d;

  logic [LW-1:0]    lat_inc;
  logic [LW-1:0]    tot_inc;
  logic [SW-1:0]    settle_inc;
  logic [EW-1:0]    err_inc;
  logic [EW:0]      err_sum;
  logic [EW-1:0]    err_chk;

  // Saturating increments and the CHECK-cycle error accumulation
  always_comb begin
    lat_inc    = (lat_cnt == '1) ? lat_cnt : lat_cnt + LW'(1);
    tot_inc    = (tot_q == '1) ? tot_q : tot_q + LW'(1);
    err_inc    = (err_count == '1) ? err_count : err_count + EW'(1);
    settle_inc = '0;
    if (osizedreg == prev_sz_q) begin
      settle_inc = (settle_q == '1) ? settle_q : settle_q + SW'(1);
    end
    err_sum = (EW+1)'(err_count)
            + (EW+1)'(osizedreg != exp_q)
            + (EW+1)'(tied != TIED_EXP)
            + (EW+1)'(oonewire != 1'b1);
    err_chk = (err_sum > (EW+1)'(15)) ? EW'(15) : EW'(err_sum);
  end

  // Next-state and next-result logic
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    settle_d = settle_q;
    tot_d    = tot_q;
    err_d    = err_count;
    lat_d    = lat_cnt;
    to_d     = timeout;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          exp_d    = exp_sized;
          err_d    = '0;
          lat_d    = '0;
          to_d     = 1'b0;
          settle_d = '0;
          tot_d    = '0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        lat_d = lat_inc;
        // Arrival wins over a timeout landing in the same cycle
        if (oonewire) begin
          settle_d = '0;
          tot_d    = '0;
          state_d  = S_SETTLE;
        end else if (lat_inc >= TIMEOUT_L) begin
          to_d    = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_SETTLE: begin
        tot_d    = tot_inc;
        settle_d = settle_inc;
        if (!oonewire && prev_one_q) begin
          err_d = err_inc;
        end
        if (settle_inc == SETTLE_S) begin
          state_d = S_CHECK;
        end else if (tot_inc >= TIMEOUT_L) begin
          to_d    = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_CHECK: begin
        err_d   = err_chk;
        state_d = (err_chk == '0) ? S_PASS : S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered results and datapath history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q      <= '0;
      prev_sz_q  <= '0;
      prev_one_q <= 1'b0;
      settle_q   <= '0;
      tot_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      lat_cnt    <= '0;
    end else begin
      exp_q      <= exp_d;
      prev_sz_q  <= osizedreg;
      prev_one_q <= oonewire;
      settle_q   <= settle_d;
      tot_q      <= tot_d;
      busy       <= (state_d == S_ARM) || (state_d == S_SETTLE) || (state_d == S_CHECK);
      done       <= (state_d == S_PASS) || (state_d == S_FAIL);
      pass       <= (state_d == S_PASS);
      fail       <= (state_d == S_FAIL);
      timeout    <= to_d;
      err_count  <= err_d;
      lat_cnt    <= lat_d;
    end
  end

endmodule

// File: tb/tb_inst_v2k_resp_chk.sv
// Bench for inst_v2k_resp_chk: directed spec cases plus random upstream traces
// checked against a trace-scanning outcome model.
module tb_inst_v2k_resp_chk;

  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned SETTLE   = 2;
  localparam logic [1:0]  TIED_EXP = 2'b10;
  localparam int          NMAX     = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] exp_sized = '0;
  logic [7:0] osizedreg = '0;
  logic       oonewire = 1'b0;
  logic [1:0] tied = '0;
  logic       busy, done, pass, fail, timeout;
  logic [3:0] err_count;
  logic [7:0] lat_cnt;

  int checks = 0;
  int errors = 0;

  // Upstream trace, indexed by clock edge after the start edge (0 = start edge)
  logic [7:0] a_sz   [0:NMAX];
  logic       a_one  [0:NMAX];
  logic [1:0] a_tied [0:NMAX];
  logic       a_start[0:NMAX];

  int   done_at;
  int   m_done, m_err, m_lat;
  logic m_pass, m_to;

  inst_v2k_resp_chk #(
    .WIDTH(8), .TIED_EXP(TIED_EXP), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .exp_sized(exp_sized),
    .osizedreg(osizedreg), .oonewire(oonewire), .tied(tied),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .lat_cnt(lat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [7:0] sz, input logic one, input logic [1:0] td);
    for (int t = 0; t <= NMAX; t++) begin
      a_sz[t] = sz; a_one[t] = one; a_tied[t] = td; a_start[t] = 1'b0;
    end
  endtask

  // Pulse start with expected value e, then play the trace until done or NMAX edges
  task automatic run(input logic [7:0] e);
    @(negedge clk);
    start = 1'b1; exp_sized = e;
    osizedreg = a_sz[0]; oonewire = a_one[0]; tied = a_tied[0];
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    done_at = -1;
    for (int t = 1; t <= NMAX && done_at < 0; t++) begin
      start = a_start[t]; exp_sized = 8'($urandom);
      osizedreg = a_sz[t]; oonewire = a_one[t]; tied = a_tied[t];
      @(posedge clk); #1;
      if (done) done_at = t;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int d, input logic p,
                              input logic to, input int err, input int lat);
    int e_hold;
    chk({tag, ".done_at"}, done_at, d);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".pass"}, pass, p);
    chk({tag, ".fail"}, fail, !p);
    chk({tag, ".timeout"}, timeout, to);
    chk({tag, ".err"}, err_count, err);
    chk({tag, ".lat"}, lat_cnt, lat);
    e_hold = err;
    for (int i = 0; i < 3; i++) begin
      osizedreg = 8'($urandom); oonewire = 1'($urandom); tied = 2'($urandom);
      @(posedge clk); #1;
    end
    chk({tag, ".hold_done"}, done, 1);
    chk({tag, ".hold_err"}, err_count, e_hold);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Outcome from scanning the trace: first arrival, then stable run length, then one compare
  task automatic model(input logic [7:0] e);
    int  k, run_len;
    bit  arrived, settled;
    m_err = 0; m_to = 1'b0; m_pass = 1'b0; arrived = 0; k = 0;
    for (int t = 1; t <= int'(TIMEOUT); t++)
      if (!arrived && a_one[t]) begin arrived = 1; k = t; end
    if (!arrived) begin
      m_lat = TIMEOUT; m_done = TIMEOUT; m_to = 1'b1;
      return;
    end
    m_lat = k; run_len = 0; settled = 0;
    for (int j = k + 1; j <= k + int'(TIMEOUT) && !settled; j++) begin
      if (a_one[j-1] && !a_one[j]) m_err = sat15(m_err + 1);
      run_len = (a_sz[j] == a_sz[j-1]) ? run_len + 1 : 0;
      if (run_len == int'(SETTLE)) begin
        settled = 1;
        m_done  = j + 1;
        m_err   = sat15(m_err + int'(a_sz[j+1] != e) + int'(a_tied[j+1] != TIED_EXP)
                        + int'(a_one[j+1] != 1'b1));
      end
    end
    if (!settled) begin m_to = 1'b1; m_done = k + TIMEOUT; end
    m_pass = settled && (m_err == 0);
  endtask

  initial begin
    logic [7:0] base, e;
    int         k;

    // Reset state
    #12;
    chk("rst.busy", busy, 0); chk("rst.done", done, 0); chk("rst.pass", pass, 0);
    chk("rst.fail", fail, 0); chk("rst.timeout", timeout, 0);
    chk("rst.err", err_count, 0); chk("rst.lat", lat_cnt, 0);
    @(negedge clk); rst = 1'b0;

    // Nominal: done visible in the 5th cycle after start (set on edge 4)
    fill(8'd8, 1'b1, 2'b10); run(8'd8);
    check_result("nominal", 4, 1'b1, 1'b0, 0, 1);

    fill(8'd8, 1'b1, 2'b01); run(8'd8);
    check_result("wrong_tie", 4, 1'b0, 1'b0, 1, 1);

    fill(8'd7, 1'b1, 2'b00); run(8'd8);
    check_result("double_mm", 4, 1'b0, 1'b0, 2, 1);

    fill(8'd8, 1'b0, 2'b10); run(8'd8);
    check_result("timeout", 16, 1'b0, 1'b1, 0, 16);

    fill(8'd8, 1'b0, 2'b10);
    for (int t = 16; t <= NMAX; t++) a_one[t] = 1'b1;
    run(8'd8);
    check_result("late_arrival", 19, 1'b1, 1'b0, 0, 16);

    fill(8'd8, 1'b1, 2'b10);
    a_sz[2] = 8'd9; a_sz[3] = 8'd8; a_sz[4] = 8'd9;
    run(8'd8);
    check_result("unstable", 8, 1'b1, 1'b0, 0, 1);

    fill(8'd8, 1'b1, 2'b10);
    for (int t = 1; t <= NMAX; t++) a_sz[t] = t[0] ? 8'd9 : 8'd8;
    run(8'd8);
    check_result("toggling", 17, 1'b0, 1'b1, 0, 1);

    // Reset during SETTLE clears everything asynchronously
    fill(8'd8, 1'b1, 2'b10);
    @(negedge clk); start = 1'b1; exp_sized = 8'd8;
    osizedreg = 8'd8; oonewire = 1'b1; tied = 2'b10;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst.busy", busy, 1); chk("pre_rst.lat", lat_cnt, 1);
    #2 rst = 1'b1; #1;
    chk("mid_rst.busy", busy, 0); chk("mid_rst.done", done, 0);
    chk("mid_rst.pass", pass, 0); chk("mid_rst.fail", fail, 0);
    chk("mid_rst.timeout", timeout, 0); chk("mid_rst.err", err_count, 0);
    chk("mid_rst.lat", lat_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.busy", busy, 0); chk("post_rst.done", done, 0);

    fill(8'hA5, 1'b1, 2'b10); run(8'hA5);
    check_result("restart_a5", 4, 1'b1, 1'b0, 0, 1);
    run(8'h00);
    check_result("restart_00", 4, 1'b0, 1'b0, 1, 1);

    // Random traces, including ignored mid-check start pulses
    for (int n = 0; n < 40; n++) begin
      base = 8'($urandom);
      k    = $urandom_range(1, 20);
      for (int t = 0; t <= NMAX; t++) begin
        a_one[t]   = (t >= k) ? ($urandom_range(0, 9) != 0) : 1'b0;
        a_sz[t]    = (t == 0) ? base
                   : (($urandom_range(0, 3) == 0) ? (base ^ 8'($urandom_range(0, 1))) : a_sz[t-1]);
        a_tied[t]  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : TIED_EXP;
        a_start[t] = ($urandom_range(0, 9) == 0);
      end
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
      model(e);
      run(e);
      check_result($sformatf("rand%0d", n), m_done, m_pass, m_to, m_err, m_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
